// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing front end for the 8-bit combinational ALU.
// Accepts one request, holds the ALU operands stable for SETTLE_CYCLES,
// samples the result and returns it with div0/neg status over a
// valid/ready response channel.
//
// state | meaning
// IDLE  | ready for a request; ALU inputs hold their last values
// WAIT  | ALU inputs frozen, settle counter running down to 1
// RESP  | response presented, waiting for rsp_ready
module alu_seq_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic [1:0]       alu_op_code,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic             rsp_div0,
    output logic             rsp_neg,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t           state_q;
    logic [3:0]       settle_q;
    logic [1:0]       op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             div0_q;
    logic             neg_q;
    logic [15:0]      result_q;
    logic             rsp_valid_q;
    logic             rsp_div0_q;
    logic             rsp_neg_q;
    logic [CNT_W-1:0] op_count_q;

    logic             div0_d;
    logic             neg_d;

    // Status flags are decided from the request operands at accept time,
    // independent of what the ALU returns.
    always_comb begin
        div0_d = (req_op == 2'b11) && (req_b == 8'd0);
        neg_d  = (req_op == 2'b01) && (req_a < req_b);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= 4'd0;
            op_q        <= 2'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            div0_q      <= 1'b0;
            neg_q       <= 1'b0;
            result_q    <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_div0_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        a_q      <= req_a;
                        b_q      <= req_b;
                        div0_q   <= div0_d;
                        neg_q    <= neg_d;
                        settle_q <= SETTLE_LD;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    settle_q <= settle_q - 4'd1;
                    if (settle_q == 4'd1) begin
                        result_q    <= alu_result;
                        rsp_div0_q  <= div0_q;
                        rsp_neg_q   <= neg_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_div0_q  <= 1'b0;
                        rsp_neg_q   <= 1'b0;
                        op_count_q  <= op_count_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake readiness derives only from state.
    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    assign alu_op_code = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = result_q;
    assign rsp_div0    = rsp_div0_q;
    assign rsp_neg     = rsp_neg_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing front end for the team's 8-bit combinational ALU.
- ALU op codes: 00 add, 01 sub, 10 mul, 11 div. Result is 16 bits. Divide-by-zero returns 16'hFFFF.
- This block accepts one operation request over a valid/ready handshake and drives registered operands into the ALU.
- It waits a programmable settle time, then captures the ALU result and returns it with status flags over a second valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 1, number of cycles the ALU inputs are held stable before the result is sampled. Legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  requested op code.
- req_a  input  8  operand a.
- req_b  input  8  operand b.
- alu_op_code  output  2  registered op code driven to the ALU.
- alu_a  output  8  registered operand a driven to the ALU.
- alu_b  output  8  registered operand b driven to the ALU.
- alu_result  input  16  combinational ALU result.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  16  captured result.
- rsp_div0  output  1  op was 11 with b == 0.
- rsp_neg  output  1  op was 01 with a < b (result is a 16-bit two's-complement negative).
- op_count  output  CNT_W  number of completed response handshakes. Wraps modulo 2^CNT_W.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; the settle counter goes to 0.
  - alu_op_code, alu_a, alu_b, rsp_result and op_count go to 0.
  - rsp_valid, rsp_div0 and rsp_neg go to 0.
  - Reset outranks every other event. Reset in WAIT or RESP abandons the operation; no response is produced and op_count does not increment.
- States: IDLE, WAIT, RESP.
- req_ready = (state == IDLE), purely from state. busy = (state != IDLE).
- IDLE:
  - On req_valid && req_ready at an edge, register req_op/req_a/req_b into alu_op_code/alu_a/alu_b.
  - Compute and register the div0 and neg flags from the request operands.
  - Load the settle counter with SETTLE_CYCLES and go to WAIT.
  - Without req_valid, all registers hold.
- WAIT:
  - ALU outputs stay frozen; req_ready is 0, so new requests are not accepted.
  - The counter decrements each cycle.
  - At the edge where the counter equals 1: capture alu_result into rsp_result, drive the registered flags onto rsp_div0/rsp_neg, set rsp_valid, go to RESP.
- Latency: rsp_valid is high exactly SETTLE_CYCLES cycles after the accepting edge.
- RESP:
  - rsp_valid, rsp_result and the flags are held stable until rsp_ready is sampled high.
  - On that edge: clear rsp_valid, increment op_count, go to IDLE.
  - The ALU input registers keep their last values; no clearing.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. The next accept is possible on the first edge after the response handshake. No request is ever buffered.
- Divide-by-zero:
  - The op is still issued to the ALU, and rsp_result is whatever the ALU returns (16'hFFFF).
  - rsp_div0 = 1 in that response only.
- rsp_neg is set only for op 01 with a < b. rsp_result is then the zero-extended 16-bit wrap of a-b, e.g. 5-10 = 16'hFFFB.
- rsp_div0 and rsp_neg are meaningful only while rsp_valid = 1. They are cleared with rsp_valid.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- req_valid or rsp_ready high in states where they are not consulted has no effect.

Test Plan:
- Add with SETTLE_CYCLES=1: a=200, b=100, op=00 -> rsp_valid rises 1 cycle after accept, rsp_result=16'h012C, div0=0, neg=0, op_count=1 after handshake.
- Sub: a=5, b=10, op=01 -> rsp_result=16'hFFFB, rsp_neg=1. Then mul 255*255, op=10 -> rsp_result=16'hFE01, rsp_neg=0.
- Divide-by-zero: a=100, b=0, op=11 -> rsp_result=16'hFFFF, rsp_div0=1. Then a=100, b=7 -> rsp_result=16'h000E, rsp_div0=0.
- Backpressure: hold rsp_ready low 5 cycles while req_valid stays high with new operands -> req_ready=0 throughout; rsp outputs and alu_a/alu_b unchanged. Raising rsp_ready completes the response; the new request is accepted on the next edge.
- Reset mid-op with SETTLE_CYCLES=4: assert rst_n low during the second WAIT cycle -> after the edge, state IDLE, rsp_valid=0, op_count unchanged at its reset value 0, ALU outputs 0. No response is produced after release.
- Counter wrap with CNT_W=2: complete 5 operations back-to-back with rsp_ready tied high -> op_count sequence 1,2,3,0,1. Accept-to-accept spacing is SETTLE_CYCLES+2 cycles.
